// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: one registered one-hot grant, held until done or HOLD_MAX cycles.
// Optional per-requester starvation monitor enabled by defining RR_WAIT_MON_EN.
module rr_wait_lane #(
    parameter int WAIT_MAX = 20,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    input  logic clr_err,
    output logic starve
);
    logic [CNT_W-1:0] cnt;
    logic             at_max;

    assign at_max = (cnt == CNT_W'(WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            starve <= 1'b0;
        end else begin
            if (req && !gnt)
                cnt <= at_max ? cnt : cnt + 1'b1;
            else
                cnt <= '0;
            // a new set takes priority over a same-cycle clear
            if (at_max)
                starve <= 1'b1;
            else if (clr_err)
                starve <= 1'b0;
        end
    end
endmodule

module rr_grant_sched #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 15,
    parameter int WAIT_MAX = 20,
    parameter int CNT_W    = 8,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    input  logic            clr_err,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            hold_to,
    output logic [NREQ-1:0] starve
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   ptr, ptr_n, winner, id_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [NREQ-1:0]  gnt_n;
    logic             found, hold_to_n;

    // first requester at or after ptr, wrapping
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_to  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            gnt_id   <= id_n;
            hold_to  <= hold_to_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        id_n      = gnt_id;
        hold_to_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    gnt_n   = NREQ'(1) << winner;
                    id_n    = winner;
                    hold_n  = CNT_W'(1);
                end
            end
            BUSY: begin
                if (done || hold_cnt == CNT_W'(HOLD_MAX)) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    id_n      = '0;
                    hold_n    = '0;
                    ptr_n     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                    hold_to_n = !done;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

`ifdef RR_WAIT_MON_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_mon
        rr_wait_lane #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req[i]),
            .gnt     (gnt[i]),
            .clr_err (clr_err),
            .starve  (starve[i])
        );
    end
`else
    logic unused_clr;
    assign unused_clr = clr_err;
    assign starve     = '0;
`endif
endmodule
